// File: rtl/any1_reorder_buffer_pkg.sv
// Shared ANY-1 retirement types: ROB entry and
// the decode/execute bundles bound to the buffer.
package any1_reorder_buffer_pkg;

  localparam int ROB_ENTRIES = 16;
  localparam int AWID = 32;
  localparam int RID_W = $clog2(ROB_ENTRIES);

  localparam logic [15:0] FLT_NONE = 16'h0000;
  localparam logic TRUE = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef struct packed {
    logic v;
    logic cmt;
    logic [AWID-1:0] ip;
    logic rfwr;
    logic [7:0] Rt;
    logic [5:0] epoch;
    logic [63:0] res;
    logic [15:0] cause;
    logic jump;
    logic [63:0] jump_tgt;
  } sReorderEntry;

  typedef struct packed {
    logic [AWID-1:0] ip;
    logic rfwr;
    logic [7:0] Rt;
  } sRobAlloc;

  typedef struct packed {
    logic [RID_W-1:0] rid;
    logic [5:0] epoch;
    logic [63:0] res;
    logic [15:0] cause;
    logic jump;
    logic [63:0] jump_tgt;
  } sRobWb;

endpackage

// File: rtl/any1_reorder_buffer.sv
// ANY-1 reorder buffer: in-order allocate and retire,
// out-of-order writeback, epoch-tagged flush.
module any1_reorder_buffer #(
  parameter int ROB_ENTRIES = 16,
  parameter int AWID = 32,
  localparam int RW = $clog2(ROB_ENTRIES)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          alloc_v_i,
  input  logic [AWID-1:0] alloc_ip_i,
  input  logic          alloc_rfwr_i,
  input  logic [7:0]    alloc_Rt_i,
  output logic          alloc_rdy_o,
  output logic [RW-1:0] alloc_rid_o,
  output logic [5:0]    epoch_o,
  input  logic          wb_v_i,
  input  logic [RW-1:0] wb_rid_i,
  input  logic [5:0]    wb_epoch_i,
  input  logic [63:0]   wb_res_i,
  input  logic [15:0]   wb_cause_i,
  input  logic          wb_jump_i,
  input  logic [63:0]   wb_jump_tgt_i,
  input  logic          cmt_rdy_i,
  output logic          cmt_v_o,
  output logic [AWID-1:0] cmt_ip_o,
  output logic          cmt_rfwr_o,
  output logic [7:0]    cmt_Rt_o,
  output logic [63:0]   cmt_res_o,
  output logic [15:0]   cmt_cause_o,
  output logic          flush_o,
  output logic [63:0]   flush_tgt_o,
  output logic [RW:0]   count_o,
  output logic          empty_o
);
  import any1_reorder_buffer_pkg::*;

  sReorderEntry rob [ROB_ENTRIES];
  sReorderEntry hd;
  sRobAlloc al;
  sRobWb wb;

  logic [RW-1:0] head;
  logic [RW-1:0] tail;
  logic [RW:0] count;
  logic [5:0] epoch;

  logic cmt_fire;
  logic flush;
  logic alloc_fire;
  logic wb_ok;

  assign al = '{
    ip: alloc_ip_i,
    rfwr: alloc_rfwr_i,
    Rt: alloc_Rt_i
  };

  assign wb = '{
    rid: wb_rid_i,
    epoch: wb_epoch_i,
    res: wb_res_i,
    cause: wb_cause_i,
    jump: wb_jump_i,
    jump_tgt: wb_jump_tgt_i
  };

  assign hd = rob[head];

  assign cmt_v_o = hd.v & hd.cmt;
  assign cmt_fire = cmt_v_o & cmt_rdy_i;
  assign flush = cmt_fire
    & ((hd.cause != FLT_NONE) | hd.jump);

  // count MSB set means all entries are in use
  assign alloc_rdy_o = ~count[RW] & ~flush;
  assign alloc_fire = alloc_v_i & alloc_rdy_o;

  assign wb_ok = wb_v_i
    & rob[wb.rid].v
    & (rob[wb.rid].epoch == wb.epoch)
    & ~flush
    & ~(alloc_fire & (wb.rid == tail));

  assign alloc_rid_o = tail;
  assign epoch_o = epoch;
  assign count_o = count;
  assign empty_o = (count == '0);

  assign cmt_ip_o = hd.ip;
  assign cmt_rfwr_o = hd.rfwr;
  assign cmt_Rt_o = hd.Rt;
  assign cmt_res_o = hd.res;
  assign cmt_cause_o = hd.cause;

  assign flush_o = flush;
  // traps carry no target; vectoring happens downstream
  assign flush_tgt_o =
    (flush & (hd.cause == FLT_NONE))
    ? hd.jump_tgt : 64'd0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < ROB_ENTRIES; i++)
        rob[i] <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
      epoch <= '0;
    end else if (flush) begin
      for (int i = 0; i < ROB_ENTRIES; i++) begin
        rob[i].v <= FALSE;
        rob[i].cmt <= FALSE;
      end
      head <= head + 1'b1;
      tail <= head + 1'b1;
      count <= '0;
      epoch <= epoch + 6'd1;
    end else begin
      if (wb_ok) begin
        rob[wb.rid].res <= wb.res;
        rob[wb.rid].cause <= wb.cause;
        rob[wb.rid].jump <= wb.jump;
        rob[wb.rid].jump_tgt <= wb.jump_tgt;
        rob[wb.rid].cmt <= TRUE;
      end
      if (cmt_fire) begin
        rob[head].v <= FALSE;
        head <= head + 1'b1;
      end
      if (alloc_fire) begin
        rob[tail] <= '{
          v: TRUE,
          cmt: FALSE,
          ip: al.ip,
          rfwr: al.rfwr,
          Rt: al.Rt,
          epoch: epoch,
          res: 64'd0,
          cause: FLT_NONE,
          jump: FALSE,
          jump_tgt: 64'd0
        };
        tail <= tail + 1'b1;
      end
      unique case (1'b1)
        alloc_fire & ~cmt_fire: count <= count + 1'b1;
        cmt_fire & ~alloc_fire: count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/any1_reorder_buffer.md
Name: any1_reorder_buffer

Overview:
- In-order retirement buffer for the ANY-1 pipeline, ROB_ENTRIES deep.
- Decode allocates entries in program order and receives a 4-bit rid for each.
- Execute and memory units write results back out of order, tagged by rid and epoch.
- Head entries retire in order toward the register file; a faulting or jumping entry flushes all younger entries and bumps the epoch.

Parameters:
- ROB_ENTRIES, 16, number of entries; power of two; rid width = $clog2(ROB_ENTRIES)
- AWID, 32, instruction address width

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- alloc_v_i  in  1  allocation request
- alloc_ip_i  in  AWID  instruction address
- alloc_rfwr_i  in  1  instruction writes the register file
- alloc_Rt_i  in  8  target register
- alloc_rdy_o  out  1  entry can be accepted this cycle
- alloc_rid_o  out  4  rid assigned (= tail)
- epoch_o  out  6  current epoch; decode stamps instructions with it
- wb_v_i  in  1  writeback valid
- wb_rid_i  in  4  writeback entry
- wb_epoch_i  in  6  epoch of the writing instruction
- wb_res_i  in  64  result
- wb_cause_i  in  16  fault cause, 0 = FLT_NONE
- wb_jump_i  in  1  instruction redirects flow
- wb_jump_tgt_i  in  64  redirect target
- cmt_rdy_i  in  1  register file accepts a commit
- cmt_v_o  out  1  head is committable
- cmt_ip_o  out  AWID  head address
- cmt_rfwr_o  out  1  head writes the register file
- cmt_Rt_o  out  8  head target register
- cmt_res_o  out  64  head result
- cmt_cause_o  out  16  head cause
- flush_o  out  1  flush pulse
- flush_tgt_o  out  64  redirect target (valid with flush_o)
- count_o  out  5  occupied entries
- empty_o  out  1  count_o == 0

Behaviour:
- State: array of sReorderEntry; head and tail rid pointers, wrapping modulo ROB_ENTRIES; 5-bit count; 6-bit epoch.
- Reset (rst_ni low, async): all entries have v=0 and cmt=0; head=tail=0; count=0; epoch=0.
  - Outputs during reset: alloc_rdy_o=1, alloc_rid_o=0, epoch_o=0, cmt_v_o=0, flush_o=0, count_o=0, empty_o=1, all data outputs 0.
- Allocate fire = alloc_v_i & alloc_rdy_o.
  - alloc_rdy_o = (count < ROB_ENTRIES) & ~flush_o.
  - On fire, entry[tail] gets v=1, cmt=0, ip, rfwr, Rt, epoch=epoch_o, cause=0, res=0; tail increments.
  - Allocate when full is blocked (alloc_rdy_o=0). The request is not lost; decode holds it.
- Writeback, registered, 1-cycle latency.
  - Accepted only if wb_v_i & entry[wb_rid_i].v & (entry epoch == wb_epoch_i) & ~flush_o; otherwise silently dropped.
  - On accept: res, cause, jump, jump_tgt are written and cmt=1.
  - A repeat writeback to an already-cmt entry overwrites the fields.
  - A writeback and an allocate to the same rid in the same cycle cannot both be valid; the allocate wins.
- Commit, combinational outputs from entry[head].
  - cmt_v_o = entry[head].v & entry[head].cmt.
  - Fire = cmt_v_o & cmt_rdy_i. On fire, entry[head].v=0 and head increments.
  - A writeback to the head in cycle N gives cmt_v_o=1 in cycle N+1 at the earliest.
  - Maximum one commit per cycle.
- Flush = commit fire on an entry with cause != 0 or jump=1.
  - flush_o=1 in that same cycle, combinational.
  - flush_tgt_o = jump_tgt; it is 0 when cause != 0 (trap vectoring is done downstream).
  - Next cycle: all entries v=0, tail=head (the advanced head), count=0, epoch=epoch+1 mod 64.
  - A coinciding allocate is blocked; a coinciding writeback is dropped.
- Count update: alloc fire with no commit fire → +1; commit fire with no alloc fire → −1; both → unchanged; flush overrides all to 0.
- Epoch wraps 63→0.
- Reset asserted mid-operation clears all state immediately, regardless of pending writebacks or commits.

Decomposition:
- Already in the shared package: sReorderEntry, ROB_ENTRIES, FLT_NONE, TRUE/FALSE, AWID.
- Add to the package: a sRobAlloc struct (ip, rfwr, Rt) and a sRobWb struct (rid, epoch, res, cause, jump, jump_tgt) so decode and execute bind identical bundles.
- No sub-module needed; the entry array plus pointer logic stays in one module.

Test Plan:
- Reset, then 3 allocs (Rt=1,2,3) → alloc_rid_o 0,1,2, count_o=3. Writebacks in order rid2, rid0, rid1 (res=0x22, 0x00, 0x11) with cmt_rdy_i=1 → commits Rt1/0x00, Rt2/0x11, Rt3/0x22 on consecutive cycles, in order; empty_o=1 afterwards.
- 16 allocs with no writebacks → alloc_rdy_o=0 and count_o=16. A 17th request is held. Writeback and commit rid0 → the 17th request gets rid 0 and count stays 16.
- Alloc 4 entries; writeback rid1 with jump=1, tgt=0x1000; writeback rid0 → rid0 commits, then rid1 commits with flush_o=1 and flush_tgt_o=0x1000. Next cycle: count=0, epoch_o=1, head=tail=2.
- After the flush, a late writeback to rid3 carrying epoch 0 → dropped. Allocate again → new entry gets rid 2; cmt_v_o stays 0 until a writeback arrives with epoch 1.
- cmt_rdy_i=0 while the head is committable for 5 cycles → cmt_v_o stays 1 and nothing retires. Raising cmt_rdy_i → exactly one retire per cycle.
- Pulse rst_ni low asynchronously mid-stream with count=7 → outputs take reset values immediately; the first alloc after release gets rid 0.
